// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared types, size encodings and helpers for the CPU-side SRAM-like bridges
package cpu_bus_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } bridge_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Reads (0000) and full-word stores both map to a word transfer.
    function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
        case (wen)
            4'b0011, 4'b1100:                    wen_to_size = SIZE_HALF;
            4'b0001, 4'b0010, 4'b0100, 4'b1000:  wen_to_size = SIZE_BYTE;
            default:                             wen_to_size = SIZE_WORD;
        endcase
    endfunction

    // Byte-enable patterns the pipeline is allowed to produce.
    function automatic logic wen_legal(input logic [3:0] wen);
        case (wen)
            4'b0000, 4'b1111, 4'b0011, 4'b1100,
            4'b0001, 4'b0010, 4'b0100, 4'b1000: wen_legal = 1'b1;
            default:                            wen_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sram_like_bridge_if.sv
// rtl/sram_like_bridge_if.sv - SRAM-like bus between a bridge (master) and the AXI-facing side (slave)
interface sram_like_bridge_if #(
    parameter int ADDR_W = 32
);
    import cpu_bus_pkg::*;

    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_like_bridge.sv
// rtl/sram_like_bridge.sv - SRAM to SRAM-like converter with stall hold and abort drain
module sram_like_bridge
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int WRITE_EN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sram_en,
    input  logic [3:0]          sram_wen,
    input  logic [ADDR_W-1:0]   sram_addr,
    input  logic [DATA_W-1:0]   sram_wdata,
    output logic [DATA_W-1:0]   sram_rdata,
    output logic                stall,
    input  logic                longest_stall,
    input  logic                abort,
    sram_like_bridge_if.master  bus
);

    localparam logic WRITES_OK = (WRITE_EN != 0);

    bridge_state_t     state;
    bridge_state_t     state_next;
    logic [DATA_W-1:0] hold_q;
    logic              req_c;
    logic              stall_c;
    logic              capture;

    // State register; reset drops any outstanding access back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Holding register only loads a response that belongs to a live access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (capture) begin
            hold_q <= bus.rdata;
        end
    end

    // Next-state, request and stall decode.
    always_comb begin
        state_next = state;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                req_c   = sram_en & ~abort;
                stall_c = sram_en;
                if (sram_en && !abort && bus.addr_ok) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                stall_c = sram_en;
                if (abort) begin
                    state_next = bus.data_ok ? IDLE : DRAIN;
                end else if (bus.data_ok) begin
                    state_next = DONE;
                    capture    = 1'b1;
                end
            end
            DONE: begin
                if (!longest_stall || abort) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                stall_c = sram_en;
                if (bus.data_ok) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held so the bus sees no request.
    assign bus.req    = req_c & ~rst;
    assign stall      = stall_c & ~rst;
    assign bus.addr   = sram_addr;
    assign bus.wdata  = sram_wdata;
    assign bus.wr     = WRITES_OK & (|sram_wen);
    assign bus.size   = WRITES_OK ? wen_to_size(sram_wen) : SIZE_WORD;
    assign sram_rdata = hold_q;

    // Byte enables outside the legal set would be silently sent as a word.
    a_wen_legal: assert property (@(posedge clk) disable iff (rst)
        !(WRITES_OK && sram_en) || wen_legal(sram_wen));

endmodule

// File: tb/tb_sram_like_bridge.sv
// tb/tb_sram_like_bridge.sv - directed self-checking bench for sram_like_bridge
module tb_sram_like_bridge;
    import cpu_bus_pkg::*;

    logic        clk;
    logic        rst;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        stall;
    logic [31:0] sram_rdata_ro;
    logic        stall_ro;
    logic        longest_stall;
    logic        abort;

    int total;
    int fails;

    sram_like_bridge_if #(.ADDR_W(32)) bus ();
    sram_like_bridge_if #(.ADDR_W(32)) bus_ro ();

    sram_like_bridge #(.ADDR_W(32), .WRITE_EN(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .sram_en       (sram_en),
        .sram_wen      (sram_wen),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_rdata    (sram_rdata),
        .stall         (stall),
        .longest_stall (longest_stall),
        .abort         (abort),
        .bus           (bus)
    );

    sram_like_bridge #(.ADDR_W(32), .WRITE_EN(0)) dut_ro (
        .clk           (clk),
        .rst           (rst),
        .sram_en       (sram_en),
        .sram_wen      (sram_wen),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_rdata    (sram_rdata_ro),
        .stall         (stall_ro),
        .longest_stall (longest_stall),
        .abort         (abort),
        .bus           (bus_ro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    function automatic logic [31:0] st(input bridge_state_t s);
        return {30'd0, s};
    endfunction

    logic [3:0]  size_wen  [4];
    logic [31:0] size_addr [4];
    logic [31:0] size_wr   [4];
    logic [31:0] size_sz   [4];

    initial begin
        total = 0;
        fails = 0;
        size_wen  = '{4'b1111, 4'b1100, 4'b0100, 4'b0000};
        size_addr = '{32'h8000_0000, 32'h8000_0002, 32'h8000_0002, 32'h8000_0000};
        size_wr   = '{32'd1, 32'd1, 32'd1, 32'd0};
        size_sz   = '{32'd2, 32'd1, 32'd0, 32'd2};

        rst = 1'b1; sram_en = 1'b0; sram_wen = 4'b0; sram_addr = '0; sram_wdata = '0;
        longest_stall = 1'b0; abort = 1'b0;
        bus.addr_ok = 1'b0; bus.data_ok = 1'b0; bus.rdata = '0;
        bus_ro.addr_ok = 1'b0; bus_ro.data_ok = 1'b0; bus_ro.rdata = '0;
        #3;
        check("reset_req", {31'd0, bus.req}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_rdata", sram_rdata, 32'd0);
        check("reset_state", st(dut.state), st(IDLE));

        next_cycle();
        rst = 1'b0;

        // Basic read
        next_cycle();
        sram_en = 1'b1; sram_wen = 4'b0000; sram_addr = 32'hBFC0_0000;
        look();
        check("rd_c0_req", {31'd0, bus.req}, 32'd1);
        check("rd_c0_stall", {31'd0, stall}, 32'd1);
        check("rd_c0_addr", bus.addr, 32'hBFC0_0000);
        check("rd_c0_wr", {31'd0, bus.wr}, 32'd0);
        next_cycle();
        bus.addr_ok = 1'b1;
        look();
        check("rd_c1_req", {31'd0, bus.req}, 32'd1);
        next_cycle();
        bus.addr_ok = 1'b0;
        look();
        check("rd_c2_req", {31'd0, bus.req}, 32'd0);
        check("rd_c2_stall", {31'd0, stall}, 32'd1);
        check("rd_c2_state", st(dut.state), st(WAIT));
        next_cycle();
        bus.data_ok = 1'b1; bus.rdata = 32'h3C1D_BFC0; longest_stall = 1'b1;
        look();
        check("rd_c3_stall", {31'd0, stall}, 32'd1);
        next_cycle();
        bus.data_ok = 1'b0; bus.rdata = '0; longest_stall = 1'b0;
        look();
        check("rd_c4_stall", {31'd0, stall}, 32'd0);
        check("rd_c4_rdata", sram_rdata, 32'h3C1D_BFC0);
        check("rd_c4_state", st(dut.state), st(DONE));
        next_cycle();
        sram_en = 1'b0;
        look();
        check("rd_c5_state", st(dut.state), st(IDLE));
        check("rd_c5_rdata", sram_rdata, 32'h3C1D_BFC0);
        check("rd_c5_req", {31'd0, bus.req}, 32'd0);

        // Size decode from byte enables
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            sram_en = 1'b1; sram_wen = size_wen[i]; sram_addr = size_addr[i];
            look();
            check("size_wr", {31'd0, bus.wr}, size_wr[i]);
            check("size_size", {30'd0, bus.size}, size_sz[i]);
            check("size_addr", bus.addr, size_addr[i]);
        end
        next_cycle();
        sram_wen = 4'b0001; sram_addr = 32'h8000_0003;
        look();
        check("ro_wr", {31'd0, bus_ro.wr}, 32'd0);
        check("ro_size", {30'd0, bus_ro.size}, 32'd2);
        check("rw_size_byte", {30'd0, bus.size}, 32'd0);

        // Held data while another port stalls
        next_cycle();
        sram_wen = 4'b0000; sram_addr = 32'h8000_1000; bus.addr_ok = 1'b1;
        look();
        check("hold_req", {31'd0, bus.req}, 32'd1);
        next_cycle();
        bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'hDEAD_BEEF; longest_stall = 1'b1;
        next_cycle();
        bus.data_ok = 1'b0; bus.rdata = '0;
        for (int i = 0; i < 5; i++) begin
            look();
            check("hold_stall", {31'd0, stall}, 32'd0);
            check("hold_rdata", sram_rdata, 32'hDEAD_BEEF);
            check("hold_noreq", {31'd0, bus.req}, 32'd0);
            next_cycle();
        end
        longest_stall = 1'b0;
        look();
        check("hold_release_noreq", {31'd0, bus.req}, 32'd0);
        next_cycle();
        bus.addr_ok = 1'b1;
        look();
        check("hold_next_req", {31'd0, bus.req}, 32'd1);
        check("hold_next_state", st(dut.state), st(IDLE));

        // Abort while waiting, then drain the orphaned response
        next_cycle();
        bus.addr_ok = 1'b0; abort = 1'b1;
        look();
        check("abw_stall", {31'd0, stall}, 32'd1);
        next_cycle();
        abort = 1'b0;
        look();
        check("abw_state", st(dut.state), st(DRAIN));
        check("abw_stall_en", {31'd0, stall}, 32'd1);
        check("abw_req", {31'd0, bus.req}, 32'd0);
        next_cycle();
        sram_en = 1'b0;
        look();
        check("abw_stall_noen", {31'd0, stall}, 32'd0);
        next_cycle();
        sram_en = 1'b1; bus.data_ok = 1'b1; bus.rdata = 32'h1234_5678;
        look();
        check("abw_drain_rdata", sram_rdata, 32'hDEAD_BEEF);
        next_cycle();
        bus.data_ok = 1'b0; bus.rdata = '0; bus.addr_ok = 1'b1;
        look();
        check("abw_next_req", {31'd0, bus.req}, 32'd1);
        check("abw_next_state", st(dut.state), st(IDLE));
        check("abw_after_rdata", sram_rdata, 32'hDEAD_BEEF);

        // Abort coinciding with data_ok
        next_cycle();
        bus.addr_ok = 1'b0; bus.data_ok = 1'b1; abort = 1'b1; bus.rdata = 32'hCAFE_F00D;
        look();
        check("abd_req", {31'd0, bus.req}, 32'd0);
        next_cycle();
        bus.data_ok = 1'b0; abort = 1'b0; bus.rdata = '0;
        look();
        check("abd_state", st(dut.state), st(IDLE));
        check("abd_rdata", sram_rdata, 32'hDEAD_BEEF);
        check("abd_req_again", {31'd0, bus.req}, 32'd1);

        // Abort in IDLE suppresses the request
        next_cycle();
        abort = 1'b1; bus.addr_ok = 1'b1;
        look();
        check("abi_req", {31'd0, bus.req}, 32'd0);
        next_cycle();
        abort = 1'b0; bus.addr_ok = 1'b0;
        look();
        check("abi_state", st(dut.state), st(IDLE));
        check("abi_req_back", {31'd0, bus.req}, 32'd1);

        // Asynchronous reset in the middle of WAIT
        next_cycle();
        bus.addr_ok = 1'b1;
        next_cycle();
        bus.addr_ok = 1'b0;
        #1;
        check("rstw_state_pre", st(dut.state), st(WAIT));
        #1;
        rst = 1'b1;
        #1;
        check("rstw_req", {31'd0, bus.req}, 32'd0);
        check("rstw_stall", {31'd0, stall}, 32'd0);
        check("rstw_rdata", sram_rdata, 32'd0);
        check("rstw_state", st(dut.state), st(IDLE));
        next_cycle();
        rst = 1'b0; sram_en = 1'b0;
        look();
        check("rstw_after_state", st(dut.state), st(IDLE));
        check("rstw_after_stall", {31'd0, stall}, 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
